// File: rtl/encode_pkg.sv
// encode_pkg: shared widths, W zero point and quadrature step decoding
package encode_pkg;

    localparam int ENCODE_WID      = 32;
    localparam int ENCODE_MASK_WID = 18;
    localparam int UNIT_INTER      = 6250;

    localparam logic [ENCODE_MASK_WID-1:0] W_ZERO = '1;

    typedef logic [1:0] quad_state_t;

    // Encoded as the modulo-4 position difference: 1 forward, 3 reverse, 2 illegal
    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_FWD  = 2'd1,
        STEP_ERR  = 2'd2,
        STEP_REV  = 2'd3
    } step_t;

    // Gray {A,B} to position in the forward cycle 00,01,11,10
    function automatic logic [1:0] quad_pos(input quad_state_t s);
        return {s[1], s[1] ^ s[0]};
    endfunction

    function automatic step_t quad_step(input quad_state_t prev, input quad_state_t cur);
        logic [1:0] d;
        d = quad_pos(cur) - quad_pos(prev);
        return step_t'(d);
    endfunction

endpackage

// File: rtl/quad_decoder.sv
// quad_decoder: synchronize, debounce and decode one A/B(/Z) encoder channel
module quad_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic a_i,
    input  logic b_i,
    input  logic z_i,
    output logic step_en,
    output logic step_dir,
    output logic err,
    output logic idx_rise
);
    import encode_pkg::*;

    localparam int CW = $clog2(FILTER_LEN) + 1;

    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic [2:0] filt, prev_q;
    step_t step;

    // synchronizer chain, each stage holds {a, b, z}
    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) sync_q <= '0;
        else sync_q <= {sync_q[SYNC_STAGES-2:0], a_i, b_i, z_i};

    for (genvar g = 0; g < 3; g++) begin : g_filt
        logic [CW-1:0] cnt_q;
        logic          lvl_q;
        // accept the synced level only after FILTER_LEN consecutive differing cycles
        always_ff @(posedge clk_i or negedge rst_n_i)
            if (!rst_n_i) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
            end else if (sync_q[SYNC_STAGES-1][g] == lvl_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                cnt_q <= '0;
                lvl_q <= sync_q[SYNC_STAGES-1][g];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        assign filt[g] = lvl_q;
    end

    // previous filtered levels, the reference for step and index edge detection
    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) prev_q <= '0;
        else prev_q <= filt;

    assign step     = quad_step(prev_q[2:1], filt[2:1]);
    assign step_en  = step == STEP_FWD || step == STEP_REV;
    assign step_dir = step == STEP_REV;
    assign err      = step == STEP_ERR;
    assign idx_rise = filt[0] & ~prev_q[0];

endmodule

// File: rtl/encode_sample_gen.sv
// encode_sample_gen: W/X quadrature position counters with periodic snapshot strobe
module encode_sample_gen #(
    parameter int ENCODE_WID      = encode_pkg::ENCODE_WID,
    parameter int ENCODE_MASK_WID = encode_pkg::ENCODE_MASK_WID,
    parameter int UNIT_INTER      = encode_pkg::UNIT_INTER,
    parameter int SYNC_STAGES     = 2,
    parameter int FILTER_LEN      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  enc_en_i,
    input  logic [15:0]           period_set_i,
    input  logic                  w_a_i,
    input  logic                  w_b_i,
    input  logic                  w_z_i,
    input  logic                  x_a_i,
    input  logic                  x_b_i,
    input  logic                  x_dir_inv_i,
    input  logic                  x_clear_i,
    output logic                  encode_update_o,
    output logic [ENCODE_WID-1:0] encode_w_o,
    output logic [ENCODE_WID-1:0] encode_x_o,
    output logic                  wafer_zero_flag_o,
    output logic                  quad_err_o,
    output logic [15:0]           quad_err_cnt_o
);
    import encode_pkg::*;

    logic [1:0]                 rst_sync_q;
    logic                       rst_n;
    logic                       w_step_en, w_step_dir, w_err, w_idx;
    logic                       x_step_en, x_step_dir, x_err, x_idx_unused;
    logic [ENCODE_MASK_WID-1:0] w_cnt_q, w_nxt;
    logic [ENCODE_WID-1:0]      x_cnt_q, x_nxt;
    logic [15:0]                timer_q, per_q, per_in, per_eff;
    logic                       en_q, load, wrap;
    logic [16:0]                err_sum;

    // asynchronous assert, clock-synchronized release of the internal reset
    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) rst_sync_q <= '0;
        else rst_sync_q <= {rst_sync_q[0], 1'b1};

    assign rst_n = rst_sync_q[1];

    quad_decoder #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_w_dec (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n),
        .a_i      (w_a_i),
        .b_i      (w_b_i),
        .z_i      (w_z_i),
        .step_en  (w_step_en),
        .step_dir (w_step_dir),
        .err      (w_err),
        .idx_rise (w_idx)
    );

    quad_decoder #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_x_dec (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n),
        .a_i      (x_a_i),
        .b_i      (x_b_i),
        .z_i      (1'b0),
        .step_en  (x_step_en),
        .step_dir (x_step_dir),
        .err      (x_err),
        .idx_rise (x_idx_unused)
    );

    // next counter values (index and clear override steps), period choice, error sum
    always_comb begin
        w_nxt   = w_idx ? '1 : !w_step_en ? w_cnt_q : w_step_dir ? w_cnt_q - 1'b1 : w_cnt_q + 1'b1;
        x_nxt   = x_clear_i ? '0 : !x_step_en ? x_cnt_q :
                  (x_step_dir ^ x_dir_inv_i) ? x_cnt_q - 1'b1 : x_cnt_q + 1'b1;
        per_in  = period_set_i == '0 ? 16'(UNIT_INTER) : period_set_i == 16'd1 ? 16'd2 : period_set_i;
        load    = enc_en_i && !en_q;
        per_eff = load ? per_in : per_q;
        wrap    = enc_en_i && timer_q == per_eff - 16'd1;
        err_sum = {1'b0, quad_err_cnt_o} + 17'(w_err) + 17'(x_err);
    end

    // position counters, both run independently of the update timer
    always_ff @(posedge clk_i or negedge rst_n)
        if (!rst_n) begin
            w_cnt_q <= '0;
            x_cnt_q <= '0;
        end else begin
            w_cnt_q <= w_nxt;
            x_cnt_q <= x_nxt;
        end

    // update timer; period is re-latched on enable rise and at every wrap
    always_ff @(posedge clk_i or negedge rst_n)
        if (!rst_n) begin
            timer_q <= '0;
            per_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            timer_q <= (!enc_en_i || wrap) ? '0 : timer_q + 16'd1;
            en_q    <= enc_en_i;
            if (load || wrap) per_q <= per_in;
        end

    // strobe with snapshots that include this cycle's step, plus event pulses
    always_ff @(posedge clk_i or negedge rst_n)
        if (!rst_n) begin
            encode_update_o   <= 1'b0;
            encode_w_o        <= '0;
            encode_x_o        <= '0;
            wafer_zero_flag_o <= 1'b0;
            quad_err_o        <= 1'b0;
            quad_err_cnt_o    <= '0;
        end else begin
            encode_update_o   <= wrap;
            wafer_zero_flag_o <= w_idx;
            quad_err_o        <= w_err | x_err;
            quad_err_cnt_o    <= err_sum[16] ? '1 : err_sum[15:0];
            if (wrap) begin
                encode_w_o <= ENCODE_WID'(w_nxt);
                encode_x_o <= x_nxt;
            end
        end

endmodule

// File: tb/tb_encode_sample_gen.sv
// tb_encode_sample_gen: randomized scoreboard bench for encode_sample_gen
module tb_encode_sample_gen;
    import encode_pkg::*;

    typedef struct { int t; int dw; int dx; bit idx; bit err; bit clr; } ev_t;
    typedef struct { int t; logic [31:0] w; logic [31:0] x; logic [15:0] ec; } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b1;
    logic        enc_en_i = 1'b0;
    logic [15:0] period_set_i = '0;
    logic        w_a_i = 1'b0, w_b_i = 1'b0, w_z_i = 1'b0;
    logic        x_a_i = 1'b0, x_b_i = 1'b0;
    logic        x_dir_inv_i = 1'b0, x_clear_i = 1'b0;
    logic        encode_update_o, wafer_zero_flag_o, quad_err_o;
    logic [31:0] encode_w_o, encode_x_o;
    logic [15:0] quad_err_cnt_o;

    logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    ev_t  pq[$];
    exp_t sb_q[$];
    int   cyc = 0, n_chk = 0, n_fail = 0, n_upd = 0;
    int   mw = 0, mx = 0, merr = 0, nxt = 0, err_cyc = -1, idx_cyc = -1;
    bit   active = 1'b0;
    int   xp = 0, wp = 0;

    encode_sample_gen dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .enc_en_i          (enc_en_i),
        .period_set_i      (period_set_i),
        .w_a_i             (w_a_i),
        .w_b_i             (w_b_i),
        .w_z_i             (w_z_i),
        .x_a_i             (x_a_i),
        .x_b_i             (x_b_i),
        .x_dir_inv_i       (x_dir_inv_i),
        .x_clear_i         (x_clear_i),
        .encode_update_o   (encode_update_o),
        .encode_w_o        (encode_w_o),
        .encode_x_o        (encode_x_o),
        .wafer_zero_flag_o (wafer_zero_flag_o),
        .quad_err_o        (quad_err_o),
        .quad_err_cnt_o    (quad_err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // d = +1 forward, -1 reverse, 2 illegal jump; the count lands 7 cycles after the pin change
    task automatic x_move(input int d, input int hold);
        int dx;
        dx = (d == 2) ? 0 : (x_dir_inv_i ? -d : d);
        xp += d;
        {x_a_i, x_b_i} = gray[xp & 3];
        pq.push_back('{cyc + 7, 0, dx, 1'b0, d == 2, 1'b0});
        idle(hold);
    endtask

    task automatic w_move(input int d, input int hold);
        wp += d;
        {w_a_i, w_b_i} = gray[wp & 3];
        pq.push_back('{cyc + 7, (d == 2) ? 0 : d, 0, 1'b0, d == 2, 1'b0});
        idle(hold);
    endtask

    task automatic w_index();
        w_z_i = 1'b1;
        pq.push_back('{cyc + 7, 0, 0, 1'b1, 1'b0, 1'b0});
        idle(20);
        w_z_i = 1'b0;
        idle(10);
    endtask

    task automatic x_clear();
        x_clear_i = 1'b1;
        pq.push_back('{cyc + 1, 0, 0, 1'b0, 1'b0, 1'b1});
        idle(1);
        x_clear_i = 1'b0;
        idle(10);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_update"}, 32'(encode_update_o), 0);
        check({tag, "_w"}, encode_w_o, 0);
        check({tag, "_x"}, encode_x_o, 0);
        check({tag, "_zero_flag"}, 32'(wafer_zero_flag_o), 0);
        check({tag, "_quad_err"}, 32'(quad_err_o), 0);
        check({tag, "_err_cnt"}, 32'(quad_err_cnt_o), 0);
    endtask

    // reference model: counters from issued moves, strobe times from period arithmetic
    initial forever begin
        int dw, dx, ne, p;
        bit idx, clr;
        @(posedge clk_i);
        cyc++;
        if (!rst_n_i) begin
            mw = 0; mx = 0; merr = 0; active = 1'b0;
            pq.delete();
            sb_q.delete();
        end else begin
            dw = 0; dx = 0; ne = 0; idx = 1'b0; clr = 1'b0;
            for (int i = pq.size() - 1; i >= 0; i--)
                if (pq[i].t == cyc) begin
                    dw += pq[i].dw; dx += pq[i].dx; ne += int'(pq[i].err);
                    idx |= pq[i].idx; clr |= pq[i].clr;
                    pq.delete(i);
                end
            mw = idx ? int'(W_ZERO) : (mw + dw) & int'(W_ZERO);
            mx = clr ? 0 : mx + dx;
            merr = (merr + ne > 65535) ? 65535 : merr + ne;
            if (ne != 0) err_cyc = cyc;
            if (idx) idx_cyc = cyc;
            p = (period_set_i == 0) ? UNIT_INTER : (period_set_i == 1) ? 2 : int'(period_set_i);
            if (!enc_en_i) active = 1'b0;
            else if (!active) begin
                active = 1'b1;
                nxt = cyc + p - 1;
            end else if (cyc == nxt) begin
                sb_q.push_back('{cyc, 32'(mw), 32'(mx), 16'(merr)});
                nxt = cyc + p;
            end
        end
    end

    // monitor: pops the scoreboard whenever the DUT strobes, checks event pulses
    initial forever begin
        exp_t e;
        @(negedge clk_i);
        if (rst_n_i) begin
            if (encode_update_o) begin
                if (sb_q.size() == 0) check("unexpected_update", 32'(encode_update_o), 0);
                else begin
                    e = sb_q.pop_front();
                    n_upd++;
                    check("update_cycle", cyc, e.t);
                    check("encode_w", encode_w_o, e.w);
                    check("encode_x", encode_x_o, e.x);
                    check("err_cnt_at_update", 32'(quad_err_cnt_o), 32'(e.ec));
                end
            end else if (sb_q.size() != 0 && sb_q[0].t <= cyc) begin
                check("missing_update", 32'(encode_update_o), 1);
                void'(sb_q.pop_front());
            end
            if (quad_err_o || err_cyc == cyc) begin
                check("quad_err", 32'(quad_err_o), 32'(err_cyc == cyc));
                check("quad_err_cnt", 32'(quad_err_cnt_o), merr);
            end
            if (wafer_zero_flag_o || idx_cyc == cyc)
                check("wafer_zero_flag", 32'(wafer_zero_flag_o), 32'(idx_cyc == cyc));
        end
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r, h;
        #2 rst_n_i = 1'b0;
        idle(3);
        check_all_zero("reset");
        @(posedge clk_i); #2 rst_n_i = 1'b1;
        idle(5);

        // default period, no motion; then a mid-period switch to 100
        enc_en_i = 1'b1;
        idle(2 * 6250 + 3000);
        period_set_i = 16'd100;
        idle(3400);

        // X forward/reverse, then inverted direction from a cleared counter
        repeat (100) x_move(1, 10);
        repeat (150) x_move(-1, 10);
        idle(200);
        x_clear();
        x_dir_inv_i = 1'b1;
        repeat (100) x_move(1, 10);
        idle(200);
        x_dir_inv_i = 1'b0;

        // W index, wrap forward to 0, then reverse below zero
        w_index();
        w_move(1, 10);
        w_move(-1, 10);
        w_move(-1, 10);
        idle(200);

        // illegal two-bit jump, then a 3-cycle glitch that must not count
        x_move(2, 10);
        x_a_i = ~x_a_i;
        idle(3);
        x_a_i = ~x_a_i;
        idle(200);

        // randomized mixed motion with period changes
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 15);
            h = $urandom_range(6, 14);
            if (i % 60 == 0) period_set_i = 16'($urandom_range(1, 150));
            if (i % 100 == 50) begin
                idle(10);
                x_dir_inv_i = ~x_dir_inv_i;
            end
            if (r == 0) x_move(2, h);
            else if (r < 8) x_move(r[0] ? 1 : -1, h);
            else if (r == 8) w_move(2, h);
            else w_move(r[0] ? 1 : -1, h);
        end
        idle(20);

        // minimum period: 1 is clamped to 2
        period_set_i = 16'd1;
        idle(300);

        // X = 500 then reset mid-period; pins parked at 00 so reset filters agree
        period_set_i = 16'd300;
        x_dir_inv_i  = 1'b0;
        while ((xp & 3) != 0) x_move(1, 10);
        while ((wp & 3) != 0) w_move(1, 10);
        x_clear();
        repeat (500) x_move(1, 10);
        idle(450);
        @(posedge clk_i); #2;
        rst_n_i  = 1'b0;
        enc_en_i = 1'b0;
        #1 check_all_zero("mid_reset");
        idle(3);
        @(posedge clk_i); #2 rst_n_i = 1'b1;
        idle(5);
        enc_en_i = 1'b1;
        idle(320);

        idle(10);
        check("scoreboard_drained", sb_q.size(), 0);
        check("updates_seen", 32'(n_upd >= 100), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/encode_sample_gen.md
Name: encode_sample_gen

Overview:
- Transmitter side of the encode update interface: decodes raw W (spindle) and X (stage) quadrature encoder signals into position counters.
- Emits a periodic one-cycle update strobe carrying W/X snapshots, which drives the encode interpolation block's encode_update/encode_w/encode_x inputs.
- Sits between the encoder pins and encode_process, in the 100 MHz domain.

Parameters:
- ENCODE_WID, 32, width of the W/X outputs and of the X counter.
- ENCODE_MASK_WID, 18, valid W width; W zero point is the all-ones value of this width.
- UNIT_INTER, 6250, default update period in clocks (100 MHz / 16 kHz).
- SYNC_STAGES, 2, input synchronizer depth.
- FILTER_LEN, 4, consecutive stable cycles required to accept an input level.

Ports:
- clk_i  in  1  system clock, 100 MHz.
- rst_n_i  in  1  reset; asynchronous, active-low.
- enc_en_i  in  1  enables the update timer; counters run regardless.
- period_set_i  in  16  update period in clocks; 0 selects UNIT_INTER.
- w_a_i, w_b_i, w_z_i  in  1 each  W quadrature phases and index; asynchronous.
- x_a_i, x_b_i  in  1 each  X quadrature phases; asynchronous.
- x_dir_inv_i  in  1  inverts X count direction.
- x_clear_i  in  1  synchronous clear of the X counter.
- encode_update_o  out  1  one-cycle update strobe.
- encode_w_o  out  ENCODE_WID  W snapshot, zero-extended from ENCODE_MASK_WID bits.
- encode_x_o  out  ENCODE_WID  X snapshot, two's complement.
- wafer_zero_flag_o  out  1  one-cycle pulse when the W index is accepted.
- quad_err_o  out  1  one-cycle pulse on an illegal quadrature transition, either axis.
- quad_err_cnt_o  out  16  saturating count of illegal transitions.

Behaviour:
- Reset: all outputs 0, counters 0, timer 0, filters and synchronizers 0.
- Input conditioning:
  - Each input passes through SYNC_STAGES flops, then a filter.
  - The filtered level changes only after the synced value differs from it for FILTER_LEN consecutive cycles.
  - Any revert to the filtered level restarts the filter count.
- Decoder:
  - Tracks the previous filtered {A,B}.
  - Forward sequence 00→01→11→10→00 counts +1; reverse counts −1; no change counts 0.
  - A two-bit change is illegal: no count, quad_err_o pulses, and quad_err_cnt_o increments, saturating at 0xFFFF.
- Latency: pin edge to counter update is SYNC_STAGES+FILTER_LEN+1 cycles, i.e. 7 with defaults.
- W counter:
  - ENCODE_MASK_WID bits unsigned, modulo 2^ENCODE_MASK_WID.
  - +1 at 0x3FFFF gives 0; −1 at 0 gives 0x3FFFF.
  - Filtered rising edge of w_z_i loads 0x3FFFF and pulses wafer_zero_flag_o. Index beats a step in the same cycle.
- X counter:
  - ENCODE_WID signed, wraps in two's complement.
  - Step sign is inverted when x_dir_inv_i=1.
  - x_clear_i beats a step in the same cycle.
- Timer:
  - Free-running 0..P−1 while enc_en_i=1, where P is the latched period.
  - Held at 0 while enc_en_i=0.
  - P is latched from period_set_i when enc_en_i rises and at each wrap, so a mid-period change applies to the next period. Values 1 are clamped to 2.
- Update:
  - At timer==P−1, encode_update_o=1 for one cycle.
  - encode_w_o/encode_x_o register the counter values including any step or index applied in that same cycle.
  - Outputs hold between strobes.
  - The first strobe comes P cycles after enc_en_i rises.
- Reset mid-operation clears everything immediately (asynchronous assert); deassertion is synchronized internally to clk_i.

Decomposition:
- Shared package encode_pkg:
  - ENCODE_WID, ENCODE_MASK_WID, UNIT_INTER.
  - W_ZERO constant = 2^ENCODE_MASK_WID−1.
  - 2-bit quad-state typedef and step encoding (+1, −1, 0, error).
- Sub-module quad_decoder: synchronizer, filter and decoder for one A/B(/Z) channel, outputting step_en, step_dir, err and idx_rise. Instantiated for W (with Z) and for X (Z tied 0).

Test Plan:
- Reset, period_set_i=0, enc_en_i=1, no motion → encode_update_o pulses every 6250 cycles, first pulse 6250 cycles after enable; W=0, X=0.
- 100 forward X quadrature steps, each phase held 10 cycles, then 150 reverse → next updates report 100, then 0xFFFFFFCE (−50); with x_dir_inv_i=1, 100 forward steps report −100.
- W index pulse (20 cycles) → wafer_zero_flag_o pulse, W=0x3FFFF; one forward step → 0; two reverse steps → 0x3FFFE.
- X phases jump 00→11 → X unchanged, quad_err_o pulse, quad_err_cnt_o=1; 3-cycle glitch on x_a_i → no count.
- period_set_i changed from 6250 to 100 mid-period → current period finishes at 6250, then 100-cycle spacing; period_set_i=1 → 2-cycle spacing.
- rst_n_i asserted mid-period with X=500 → all outputs 0 immediately; after release, the first strobe comes P cycles later with X=0.
